arb_8x32_ctrl: RTL and testbench
================================

ARB_8X32_CTRL -- requirements
Module: arb_8x32_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8, meaning consecutive idle cycles tolerated mid-grant before abort (legal range 2..255).
REQ-002 SHALL have port clk_4f  input  1  byte-rate clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_L  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports valid_0, valid_1  input  1 each  requester byte valid.
REQ-005 SHALL have ports data_0, data_1  input  8 each  requester byte.
REQ-006 SHALL have ports ready_0, ready_1  output  1 each  byte accepted this cycle when valid_n && ready_n.
REQ-007 SHALL have port data_in_8x32  output  8  byte forwarded to the 8-to-32 demux.
REQ-008 SHALL have port valid_in_8x32  output  1  forwarded byte valid.
REQ-009 SHALL have port selector_clk_4f  output  2  lane index of forwarded byte.
REQ-010 SHALL have port owner  output  1  requester id of forwarded byte.
REQ-011 SHALL have port word_done  output  1  pulse with the fourth byte of a word.
REQ-012 SHALL have port err_abort  output  1  one-cycle pulse on timeout abort.

Function
REQ-013 SHALL implement states IDLE and GRANT, plus registers gnt (1 bit), cnt (2 bits), rr_last (1 bit), idle_cnt (8 bits).
REQ-014 In IDLE, ready_0 = ready_1 = 0; if any valid_n is high, next state SHALL be GRANT with gnt chosen by round-robin and cnt = 0.
REQ-015 Round-robin SHALL grant the sole requester if one is valid; if both are valid, grant !rr_last; rr_last updates to the new gnt on every grant.
REQ-016 In GRANT, ready_gnt SHALL equal 1 and the other ready SHALL equal 0 (combinational from state and gnt only, not from valid).
REQ-017 On acceptance, the next cycle SHALL present data_in_8x32 = accepted byte, valid_in_8x32 = 1, selector_clk_4f = cnt at acceptance, owner = gnt (1-cycle latency, registered outputs).
REQ-018 Cycles without acceptance SHALL drive valid_in_8x32 = 0 and hold data_in_8x32, selector_clk_4f, owner unchanged.
REQ-019 cnt SHALL increment by 1 per accepted byte, modulo 4; the cnt = 3 acceptance ends the word.
REQ-020 word_done SHALL be 1 exactly in the cycle valid_in_8x32 = 1 with selector_clk_4f = 3.
REQ-021 At word end, the same cycle SHALL re-arbitrate per REQ-015 using current valid_0/valid_1 (excluding the just-accepted byte's requester only if it is not valid); grant → stay GRANT with cnt = 0, no valid → IDLE. No bubble cycle between back-to-back words.
REQ-022 idle_cnt SHALL clear on every acceptance and on entry to GRANT, and increment on each GRANT cycle without acceptance.
REQ-023 When idle_cnt reaches TIMEOUT-1 and no acceptance occurs, the next cycle SHALL: pulse err_abort = 1, enter IDLE, clear cnt and idle_cnt, leave rr_last pointing at the aborted requester (other side wins next tie).
REQ-024 After abort, the next forwarded byte SHALL carry selector_clk_4f = 0; partial-word bytes already forwarded are not retracted.
REQ-025 Valid held low by the non-granted requester SHALL never affect the current grant.

Reset
REQ-026 While reset_L = 0: state = IDLE, gnt = 0, cnt = 0, idle_cnt = 0, rr_last = 1 (requester 0 wins first tie).
REQ-027 While reset_L = 0: data_in_8x32 = 8'h00, valid_in_8x32 = 0, selector_clk_4f = 2'b00, owner = 0, word_done = 0, err_abort = 0, ready_0 = ready_1 = 0.
REQ-028 Reset asserted mid-word SHALL discard the partial word with no err_abort pulse; first grant after release follows REQ-026.

Structure
REQ-029 State encoding, lane count (4) and counter widths SHALL live in a shared constants include file used by controller and bench.
REQ-030 Round-robin decision SHALL be a combinational sub-module arb_rr2 (inputs valid_0, valid_1, rr_last; outputs gnt_valid, gnt).

Verification
REQ-031 Only requester 0, bytes 0x11,0x22,0x33,0x44 back-to-back after reset → valid_in_8x32 four consecutive cycles, selector 0,1,2,3, owner 0, word_done on 0x44.
REQ-032 Both valid continuously, req0 sends 0xA0-0xA3, req1 sends 0xB0-0xB3 → words alternate owner 0,1,0,1 with no gap cycle between words.
REQ-033 Req1 sends 0xC0,0xC1 then drops valid for 8 cycles (TIMEOUT=8) → err_abort pulse once, state IDLE, next req1 byte 0xC2 forwarded with selector 0.
REQ-034 Req0 stalls 3 cycles between bytes 2 and 3 → valid_in_8x32 low 3 cycles, selector holds 1, no err_abort, word completes with selector 3.
REQ-035 reset_L pulsed low after 2 bytes of a req0 word → all outputs zero during reset, no err_abort, both valid after release → owner 0 granted first with selector 0.

Source files
------------

// File: rtl/arb_8x32_ctrl_pkg.sv
// arb_8x32_ctrl_pkg
//   Shared constants and types for the 2-requester byte arbiter feeding the
//   8-to-32 demux. Imported by the controller, the round-robin sub-module and
//   the testbench, so state encoding and lane/counter widths live in one place.
//   No ports (package).
package arb_8x32_ctrl_pkg;

  // Four byte lanes make one 32-bit word.
  localparam int NUM_LANES  = 4;
  localparam int CNT_W      = 2;
  localparam int IDLE_CNT_W = 8;

  // Lane index carried by the last byte of a word.
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(NUM_LANES - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arbState_t;

  // True when the byte at this lane index completes a word.
  function automatic logic isLastLane(input logic [CNT_W-1:0] lane);
    return (lane == LAST_LANE);
  endfunction

endpackage

// File: rtl/arb_8x32_ctrl_rr2.sv
// arb_rr2
//   Combinational two-way round-robin decision.
//   Ports:
//     valid_0, valid_1 : request lines
//     rr_last          : requester granted most recently
//     gnt_valid        : at least one requester is asking
//     gnt              : chosen requester (meaningful only when gnt_valid)
module arb_rr2 (
  input  logic valid_0,
  input  logic valid_1,
  input  logic rr_last,
  output logic gnt_valid,
  output logic gnt
);

  // A lone requester always wins; on a tie the side not served last wins.
  always_comb begin
    gnt_valid = valid_0 | valid_1;
    gnt       = 1'b0;
    if (valid_0 && valid_1) begin
      gnt = ~rr_last;
    end else if (valid_1) begin
      gnt = 1'b1;
    end
  end

endmodule

// File: rtl/arb_8x32_ctrl.sv
// arb_8x32_ctrl
//   Arbitrates two byte streams into a single word-aligned byte stream for the
//   8-to-32 demux. A grant is held for a whole 4-byte word; stalled grants are
//   aborted after TIMEOUT idle cycles.
//   Ports:
//     clk_4f, reset_L             : byte-rate clock, async active-low reset
//     valid_0/1, data_0/1         : requester byte streams
//     ready_0/1                   : per-requester accept strobe
//     data_in_8x32, valid_in_8x32 : forwarded byte and its valid (1-cycle latency)
//     selector_clk_4f, owner      : lane index and requester id of forwarded byte
//     word_done                   : high with the fourth byte of a word
//     err_abort                   : one-cycle pulse on timeout abort
module arb_8x32_ctrl
  import arb_8x32_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 8
) (
  input  logic             clk_4f,
  input  logic             reset_L,
  input  logic             valid_0,
  input  logic             valid_1,
  input  logic [7:0]       data_0,
  input  logic [7:0]       data_1,
  output logic             ready_0,
  output logic             ready_1,
  output logic [7:0]       data_in_8x32,
  output logic             valid_in_8x32,
  output logic [CNT_W-1:0] selector_clk_4f,
  output logic             owner,
  output logic             word_done,
  output logic             err_abort
);

  localparam logic [IDLE_CNT_W-1:0] TIMEOUT_LAST = IDLE_CNT_W'(TIMEOUT - 1);

  arbState_t             r_state;
  logic                  r_gnt;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_rrLast;
  logic [IDLE_CNT_W-1:0] r_idleCnt;

  logic       w_gntValid;
  logic       w_gnt;
  logic       w_accept;
  logic [7:0] w_gntData;

  arb_rr2 u_rr2 (
    .valid_0   (valid_0),
    .valid_1   (valid_1),
    .rr_last   (r_rrLast),
    .gnt_valid (w_gntValid),
    .gnt       (w_gnt)
  );

  // Ready depends only on state and grant so a requester can raise valid
  // without a combinational loop back through ready.
  always_comb begin
    ready_0   = (r_state == ST_GRANT) && !r_gnt;
    ready_1   = (r_state == ST_GRANT) &&  r_gnt;
    w_accept  = (r_state == ST_GRANT) && (r_gnt ? valid_1 : valid_0);
    w_gntData = r_gnt ? data_1 : data_0;
  end

  // Controller and registered output stage. At a word boundary the
  // re-arbitration happens in the same cycle as the last acceptance so
  // back-to-back words have no bubble. An abort leaves rr_last on the
  // aborted requester so the other side wins the next tie.
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      r_state         <= ST_IDLE;
      r_gnt           <= 1'b0;
      r_cnt           <= '0;
      r_rrLast        <= 1'b1;
      r_idleCnt       <= '0;
      data_in_8x32    <= 8'h00;
      valid_in_8x32   <= 1'b0;
      selector_clk_4f <= '0;
      owner           <= 1'b0;
      word_done       <= 1'b0;
      err_abort       <= 1'b0;
    end else begin
      valid_in_8x32 <= 1'b0;
      word_done     <= 1'b0;
      err_abort     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_gntValid) begin
            r_state   <= ST_GRANT;
            r_gnt     <= w_gnt;
            r_rrLast  <= w_gnt;
            r_cnt     <= '0;
            r_idleCnt <= '0;
          end
        end
        ST_GRANT: begin
          if (w_accept) begin
            data_in_8x32    <= w_gntData;
            valid_in_8x32   <= 1'b1;
            selector_clk_4f <= r_cnt;
            owner           <= r_gnt;
            word_done       <= isLastLane(r_cnt);
            r_idleCnt       <= '0;
            r_cnt           <= r_cnt + 2'd1;
            if (isLastLane(r_cnt)) begin
              if (w_gntValid) begin
                r_gnt    <= w_gnt;
                r_rrLast <= w_gnt;
              end else begin
                r_state <= ST_IDLE;
              end
            end
          end else if (r_idleCnt == TIMEOUT_LAST) begin
            err_abort <= 1'b1;
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_idleCnt <= '0;
          end else begin
            r_idleCnt <= r_idleCnt + 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arb_8x32_ctrl.sv
// tb_arb_8x32_ctrl
//   Directed bench for arb_8x32_ctrl: two queue-driven requesters, a monitor
//   logging every forwarded byte, and hand-computed expectations per scenario.
module tb_arb_8x32_ctrl;
  import arb_8x32_ctrl_pkg::*;

  localparam int TIMEOUT = 8;

  logic             clk_4f = 1'b0;
  logic             reset_L = 1'b0;
  logic             valid_0 = 1'b0;
  logic             valid_1 = 1'b0;
  logic [7:0]       data_0 = 8'h00;
  logic [7:0]       data_1 = 8'h00;
  logic             ready_0;
  logic             ready_1;
  logic [7:0]       data_in_8x32;
  logic             valid_in_8x32;
  logic [CNT_W-1:0] selector_clk_4f;
  logic             owner;
  logic             word_done;
  logic             err_abort;

  int checks = 0;
  int errors = 0;
  int cycleCount = 0;
  int abortCount = 0;
  int abortCycle = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic       en0 = 1'b0;
  logic       en1 = 1'b0;
  logic       f0 = 1'b0;
  logic       f1 = 1'b0;

  logic [7:0] logData[$];
  logic [1:0] logSel[$];
  logic       logOwner[$];
  logic       logDone[$];
  int         logCyc[$];

  arb_8x32_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk_4f          (clk_4f),
    .reset_L         (reset_L),
    .valid_0         (valid_0),
    .valid_1         (valid_1),
    .data_0          (data_0),
    .data_1          (data_1),
    .ready_0         (ready_0),
    .ready_1         (ready_1),
    .data_in_8x32    (data_in_8x32),
    .valid_in_8x32   (valid_in_8x32),
    .selector_clk_4f (selector_clk_4f),
    .owner           (owner),
    .word_done       (word_done),
    .err_abort       (err_abort)
  );

  // Byte-rate clock.
  always #5 clk_4f = ~clk_4f;

  always @(posedge clk_4f) cycleCount <= cycleCount + 1;

  // Latch handshakes mid-cycle so the requester model knows what the
  // coming edge will accept.
  always @(negedge clk_4f) begin
    f0 = reset_L && valid_0 && ready_0;
    f1 = reset_L && valid_1 && ready_1;
  end

  // Requester model: pop accepted bytes just after the edge and present the
  // next queued byte while the requester is enabled.
  always @(posedge clk_4f) begin
    #1;
    if (reset_L && f0 && q0.size() > 0) void'(q0.pop_front());
    if (reset_L && f1 && q1.size() > 0) void'(q1.pop_front());
    f0 = 1'b0;
    f1 = 1'b0;
    valid_0 = en0 && (q0.size() > 0);
    data_0  = valid_0 ? q0[0] : 8'h00;
    valid_1 = en1 && (q1.size() > 0);
    data_1  = valid_1 ? q1[0] : 8'h00;
  end

  // Monitor: record every forwarded byte and every abort pulse.
  always @(negedge clk_4f) begin
    if (reset_L && valid_in_8x32) begin
      logData.push_back(data_in_8x32);
      logSel.push_back(selector_clk_4f);
      logOwner.push_back(owner);
      logDone.push_back(word_done);
      logCyc.push_back(cycleCount);
    end
    if (reset_L && err_abort) begin
      abortCount = abortCount + 1;
      abortCycle = cycleCount;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks = checks + 1;
    if (observed !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int req, input logic [7:0] b);
    if (req == 0) q0.push_back(b);
    else          q1.push_back(b);
  endtask

  task automatic clearLog();
    logData.delete();
    logSel.delete();
    logOwner.delete();
    logDone.delete();
    logCyc.delete();
  endtask

  // Wait (bounded) until n bytes have been logged; samples at negedge+1.
  task automatic waitLog(input int n, input int budget, input string tag);
    int k;
    k = 0;
    do begin
      @(negedge clk_4f);
      #1;
      k++;
    end while (logData.size() < n && k < budget);
    if (logData.size() < n) checkOutput(tag, logData.size(), n);
  endtask

  task automatic resetDut();
    reset_L = 1'b0;
    en0 = 1'b0;
    en1 = 1'b0;
    q0.delete();
    q1.delete();
    repeat (3) @(negedge clk_4f);
    #1;
    clearLog();
    abortCount = 0;
    reset_L = 1'b1;
  endtask

  function automatic logic [31:0] entry(input int kind, input int i);
    if (i >= logData.size()) return 32'hDEAD;
    case (kind)
      0:       return {24'h0, logData[i]};
      1:       return {30'h0, logSel[i]};
      2:       return {31'h0, logOwner[i]};
      default: return {31'h0, logDone[i]};
    endcase
  endfunction

  initial begin
    logic [7:0] expT1 [4];
    int         word;
    int         lane;
    logic       expOwner;
    logic [7:0] expData;
    int         k;

    // Reset state.
    repeat (2) @(negedge clk_4f);
    #1;
    checkOutput("rst_ready_0", ready_0, 0);
    checkOutput("rst_ready_1", ready_1, 0);
    checkOutput("rst_data", data_in_8x32, 8'h00);
    checkOutput("rst_valid", valid_in_8x32, 0);
    checkOutput("rst_sel", selector_clk_4f, 0);
    checkOutput("rst_owner", owner, 0);
    checkOutput("rst_done", word_done, 0);
    checkOutput("rst_abort", err_abort, 0);
    reset_L = 1'b1;

    // Single requester, one word back-to-back.
    expT1 = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) applyStimulus(0, expT1[i]);
    en0 = 1'b1;
    waitLog(4, 40, "t1_wait");
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t1_data%0d", i), entry(0, i), expT1[i]);
      checkOutput($sformatf("t1_sel%0d", i), entry(1, i), i);
      checkOutput($sformatf("t1_owner%0d", i), entry(2, i), 0);
      checkOutput($sformatf("t1_done%0d", i), entry(3, i), (i == 3) ? 1 : 0);
    end
    if (logCyc.size() >= 4) checkOutput("t1_gap", logCyc[3] - logCyc[0], 3);
    checkOutput("t1_abort", abortCount, 0);

    // Both requesters continuously valid: words alternate with no gap.
    resetDut();
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 4; i++) begin
        applyStimulus(0, 8'hA0 + 8'(i));
        applyStimulus(1, 8'hB0 + 8'(i));
      end
    end
    en0 = 1'b1;
    en1 = 1'b1;
    waitLog(16, 80, "t2_wait");
    for (int i = 0; i < 16; i++) begin
      word     = i / 4;
      lane     = i % 4;
      expOwner = word[0];
      expData  = (expOwner ? 8'hB0 : 8'hA0) + 8'(lane);
      checkOutput($sformatf("t2_data%0d", i), entry(0, i), expData);
      checkOutput($sformatf("t2_sel%0d", i), entry(1, i), lane);
      checkOutput($sformatf("t2_owner%0d", i), entry(2, i), expOwner);
    end
    if (logCyc.size() >= 16) checkOutput("t2_gap", logCyc[15] - logCyc[0], 15);

    // Timeout abort mid-word, then restart at lane 0.
    resetDut();
    applyStimulus(1, 8'hC0);
    applyStimulus(1, 8'hC1);
    en1 = 1'b1;
    waitLog(2, 20, "t3_wait");
    k = 0;
    while (abortCount == 0 && k < 20) begin
      @(negedge clk_4f);
      #1;
      k++;
    end
    checkOutput("t3_abort_seen", abortCount, 1);
    if (logCyc.size() >= 2) checkOutput("t3_abort_delay", abortCycle - logCyc[1], TIMEOUT);
    repeat (4) @(negedge clk_4f);
    #1;
    checkOutput("t3_abort_once", abortCount, 1);
    checkOutput("t3_idle_ready_1", ready_1, 0);
    checkOutput("t3_idle_ready_0", ready_0, 0);
    applyStimulus(1, 8'hC2);
    waitLog(3, 20, "t3_wait2");
    checkOutput("t3_c2_data", entry(0, 2), 8'hC2);
    checkOutput("t3_c2_sel", entry(1, 2), 0);
    checkOutput("t3_c2_owner", entry(2, 2), 1);
    checkOutput("t3_abort_final", abortCount, 1);

    // Stall of three cycles between lanes 1 and 2.
    resetDut();
    applyStimulus(0, 8'h01);
    applyStimulus(0, 8'h02);
    en0 = 1'b1;
    waitLog(2, 20, "t4_wait");
    repeat (2) begin
      @(negedge clk_4f);
      #1;
      checkOutput("t4_stall_valid", valid_in_8x32, 0);
      checkOutput("t4_stall_sel", selector_clk_4f, 1);
    end
    applyStimulus(0, 8'h03);
    applyStimulus(0, 8'h04);
    waitLog(4, 20, "t4_wait2");
    if (logCyc.size() >= 4) checkOutput("t4_stall_len", logCyc[2] - logCyc[1], 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t4_data%0d", i), entry(0, i), i + 1);
      checkOutput($sformatf("t4_sel%0d", i), entry(1, i), i);
      checkOutput($sformatf("t4_done%0d", i), entry(3, i), (i == 3) ? 1 : 0);
    end
    checkOutput("t4_abort", abortCount, 0);

    // Reset mid-word: outputs clear immediately, no abort, fresh arbitration.
    resetDut();
    for (int i = 0; i < 4; i++) applyStimulus(0, 8'hE0 + 8'(i));
    en0 = 1'b1;
    waitLog(2, 20, "t5_wait");
    reset_L = 1'b0;
    en0 = 1'b0;
    q0.delete();
    #1;
    checkOutput("t5_rst_ready_0", ready_0, 0);
    checkOutput("t5_rst_data", data_in_8x32, 8'h00);
    checkOutput("t5_rst_valid", valid_in_8x32, 0);
    checkOutput("t5_rst_sel", selector_clk_4f, 0);
    checkOutput("t5_rst_owner", owner, 0);
    checkOutput("t5_rst_done", word_done, 0);
    repeat (2) begin
      @(negedge clk_4f);
      #1;
      checkOutput("t5_rst_abort", err_abort, 0);
    end
    clearLog();
    reset_L = 1'b1;
    applyStimulus(0, 8'h50);
    applyStimulus(1, 8'h60);
    en0 = 1'b1;
    en1 = 1'b1;
    waitLog(1, 20, "t5_wait2");
    checkOutput("t5_first_owner", entry(2, 0), 0);
    checkOutput("t5_first_sel", entry(1, 0), 0);
    checkOutput("t5_first_data", entry(0, 0), 8'h50);
    checkOutput("t5_abort", abortCount, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
